// File: rtl/mc_cpu_ctrl.sv
// mc_cpu_ctrl: multicycle RV32I sequencer with fetch, decode, exec, mem and writeback
// stepping, retire counting and sticky halt on ECALL/EBREAK, illegal opcode or bus timeout.
module mc_cpu_ctrl #(
  parameter int          ACK_TIMEOUT = 16,
  parameter logic [31:0] NOP_INST    = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_q,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  input  logic        br_taken,
  output logic        reg_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic [2:0]  state,
  output logic        halted,
  output logic [1:0]  halt_cause,
  output logic [31:0] instret
);
  localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
                         S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5;
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  logic [2:0]    state_n;
  logic [1:0]    cause_n;
  logic [CW-1:0] cnt;
  logic [6:0]    op;
  logic          is_load, is_store, is_br, is_jal, is_jalr, is_sys, legal, timeout;
  assign op       = inst_q[6:0];
  assign is_load  = op == 7'b0000011;
  assign is_store = op == 7'b0100011;
  assign is_br    = op == 7'b1100011;
  assign is_jal   = op == 7'b1101111;
  assign is_jalr  = op == 7'b1100111;
  assign is_sys   = op == 7'b1110011;
  assign legal    = is_load | is_store | is_br | is_jal | is_jalr | is_sys |
                    op == 7'b0110011 | op == 7'b0010011 | op == 7'b0110111 | op == 7'b0010111;
  // cnt counts wait cycles already spent in the current FETCH/MEM visit
  assign timeout  = cnt == CW'(ACK_TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_FETCH;
      halt_cause <= 2'd0;
    end else begin
      state      <= state_n;
      halt_cause <= cause_n;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_q  <= NOP_INST;
      instret <= 32'd0;
      cnt     <= '0;
    end else begin
      if (state == S_FETCH && imem_ack) inst_q <= imem_rdata;
      if (pc_write) instret <= instret + 32'd1;
      if (state_n != state) cnt <= '0;
      else if ((state == S_FETCH || state == S_MEM) && !timeout) cnt <= cnt + 1'b1;
    end
  end
  always_comb begin
    state_n = state;
    cause_n = halt_cause;
    case (state)
      S_FETCH:
        if (imem_ack) state_n = S_DECODE;
        else if (timeout) begin
          state_n = S_HALT;
          cause_n = 2'd3;
        end
      S_DECODE:
        if (!legal || is_sys) begin
          state_n = S_HALT;
          cause_n = legal ? 2'd1 : 2'd2;
        end else state_n = S_EXEC;
      S_EXEC: state_n = (is_load || is_store) ? S_MEM : is_br ? S_FETCH : S_WB;
      S_MEM:
        if (dmem_ack) state_n = is_load ? S_WB : S_FETCH;
        else if (timeout) begin
          state_n = S_HALT;
          cause_n = 2'd3;
        end
      S_WB:    state_n = S_FETCH;
      default: state_n = S_HALT;
    endcase
  end
  // pc_write marks the retire cycle of every completed instruction
  always_comb begin
    imem_req  = rst && state == S_FETCH;
    dmem_req  = state == S_MEM;
    dmem_we   = state == S_MEM && is_store;
    reg_write = state == S_WB;
    halted    = state == S_HALT;
    pc_write  = state == S_WB || (state == S_EXEC && is_br) || (state == S_MEM && is_store && dmem_ack);
    pc_src    = state == S_WB ? (is_jal ? 2'd1 : is_jalr ? 2'd2 : 2'd0) :
                (state == S_EXEC && is_br && br_taken) ? 2'd1 : 2'd0;
  end
endmodule

// File: tb/tb_mc_cpu_ctrl.sv
// tb_mc_cpu_ctrl: scoreboard bench for the multicycle sequencer; each instruction's
// expected strobe/latency/trace is queued at issue and checked at its retire strobe.
module tb_mc_cpu_ctrl;
  localparam int          TO  = 16;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic        clk = 0, rst = 0;
  logic        imem_req, imem_ack = 0, dmem_req, dmem_we, dmem_ack = 0, br_taken = 0;
  logic        reg_write, pc_write, halted;
  logic [31:0] imem_rdata = 0, inst_q, instret;
  logic [1:0]  pc_src, halt_cause;
  logic [2:0]  state;
  int          n_checks = 0, n_fail = 0;
  logic [31:0] exp_ir = 0;
  typedef struct {
    logic        rw;
    logic [1:0]  src;
    int          cyc;
    logic [29:0] trace;
    logic        we;
    int          mreq;
    logic [31:0] ir;
  } exp_t;
  exp_t sb[$];

  mc_cpu_ctrl #(.ACK_TIMEOUT(TO), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_q(inst_q), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .br_taken(br_taken), .reg_write(reg_write), .pc_write(pc_write), .pc_src(pc_src),
    .state(state), .halted(halted), .halt_cause(halt_cause), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst = 0; imem_ack = 0; dmem_ack = 0; br_taken = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    exp_ir = 0;
    sb.delete();
  endtask

  task automatic run_inst(input string name, input logic [31:0] inst, input logic br, input int mwait,
                          input logic rw, input logic [1:0] src, input int cyc, input logic [29:0] trace,
                          input logic we, input int mreq);
    exp_t e, o;
    int m = 0, nmem = 0, nrw = 0, seen = 0;
    logic [29:0] tr = '0;
    exp_ir = exp_ir + 1;
    e = '{rw: rw, src: src, cyc: cyc, trace: trace, we: we, mreq: mreq, ir: exp_ir};
    sb.push_back(e);
    imem_rdata = inst; imem_ack = 1; br_taken = br;
    for (int c = 1; c <= 40 && seen == 0; c++) begin
      dmem_ack = state == 3'd3 && m == mwait;
      #1;
      tr = {tr[26:0], state};
      if (state == 3'd3) m++;
      if (dmem_req) begin
        nmem++;
        n_checks++;
        if (dmem_we !== e.we) begin n_fail++; $display("FAIL %s dmem_we: got %b want %b", name, dmem_we, e.we); end
      end
      if (reg_write) nrw++;
      if (pc_write) begin
        seen = c;
        o = sb.pop_front();
        n_checks++;
        if (seen !== o.cyc) begin n_fail++; $display("FAIL %s latency: got %0d want %0d", name, seen, o.cyc); end
        n_checks++;
        if (pc_src !== o.src) begin n_fail++; $display("FAIL %s pc_src: got %0d want %0d", name, pc_src, o.src); end
        n_checks++;
        if (nrw !== int'(o.rw)) begin n_fail++; $display("FAIL %s reg_write cycles: got %0d want %0d", name, nrw, o.rw); end
        n_checks++;
        if (nmem !== o.mreq) begin n_fail++; $display("FAIL %s dmem_req cycles: got %0d want %0d", name, nmem, o.mreq); end
        n_checks++;
        if (tr !== o.trace) begin n_fail++; $display("FAIL %s state trace: got %o want %o", name, tr, o.trace); end
        n_checks++;
        if (inst_q !== inst) begin n_fail++; $display("FAIL %s inst_q: got %h want %h", name, inst_q, inst); end
      end
      @(negedge clk);
      imem_ack = 0;
      dmem_ack = 0;
    end
    n_checks++;
    if (seen == 0) begin
      n_fail++;
      $display("FAIL %s no pc_write within 40 cycles", name);
      void'(sb.pop_front());
    end
    n_checks++;
    if (instret !== e.ir) begin n_fail++; $display("FAIL %s instret: got %0d want %0d", name, instret, e.ir); end
    n_checks++;
    if (state !== 3'd0) begin n_fail++; $display("FAIL %s next state: got %0d want 0", name, state); end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 0; imem_ack = 1; imem_rdata = 32'h00500093;
    #1;
    n_checks++;
    if ({state, imem_req, dmem_req, reg_write, pc_write, halted, halt_cause} !== 10'b0)
      begin n_fail++; $display("FAIL reset outputs: got %b want 0", {state, imem_req, dmem_req, reg_write, pc_write, halted, halt_cause}); end
    n_checks++;
    if (inst_q !== NOP) begin n_fail++; $display("FAIL reset inst_q: got %h want %h", inst_q, NOP); end
    n_checks++;
    if (instret !== 32'd0) begin n_fail++; $display("FAIL reset instret: got %0d want 0", instret); end
    @(negedge clk);
    rst = 1;
    exp_ir = 0;
    #1;
    n_checks++;
    if (imem_req !== 1'b1) begin n_fail++; $display("FAIL reset release imem_req: got %b want 1", imem_req); end
    @(negedge clk);
    imem_ack = 0;
    do_reset();
  endtask

  task automatic test_alu();
    run_inst("addi", 32'h00500093, 0, 0, 1, 2'd0, 4, 30'o0124, 0, 0);
    run_inst("lui", 32'h123450B7, 0, 0, 1, 2'd0, 4, 30'o0124, 0, 0);
    run_inst("jal", 32'h008000EF, 0, 0, 1, 2'd1, 4, 30'o0124, 0, 0);
  endtask

  task automatic test_mem();
    run_inst("load_wait3", 32'h0000A103, 0, 3, 1, 2'd0, 8, 30'o01233334, 0, 4);
    run_inst("load_nowait", 32'h0000A103, 0, 0, 1, 2'd0, 5, 30'o01234, 0, 1);
    run_inst("store", 32'h0020A023, 0, 0, 0, 2'd0, 4, 30'o0123, 1, 1);
    run_inst("store_wait2", 32'h0020A023, 0, 2, 0, 2'd0, 6, 30'o012333, 1, 3);
  endtask

  task automatic test_branch();
    run_inst("br_taken", 32'h00208463, 1, 0, 0, 2'd1, 3, 30'o012, 0, 0);
    run_inst("br_not_taken", 32'h00208463, 0, 0, 0, 2'd0, 3, 30'o012, 0, 0);
  endtask

  task automatic test_back_to_back();
    run_inst("jalr", 32'h000080E7, 0, 0, 1, 2'd2, 4, 30'o0124, 0, 0);
    run_inst("add", 32'h002081B3, 0, 0, 1, 2'd0, 4, 30'o0124, 0, 0);
    run_inst("auipc", 32'h00001117, 0, 0, 1, 2'd0, 4, 30'o0124, 0, 0);
  endtask

  task automatic test_ecall();
    imem_rdata = 32'h00000073; imem_ack = 1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({state, halted, halt_cause} !== {3'd5, 1'b1, 2'd1})
      begin n_fail++; $display("FAIL ecall halt: got %0d/%b/%0d want 5/1/1", state, halted, halt_cause); end
    n_checks++;
    if (instret !== exp_ir) begin n_fail++; $display("FAIL ecall instret: got %0d want %0d", instret, exp_ir); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({imem_req, dmem_req, reg_write, pc_write, state} !== {4'b0, 3'd5})
        begin n_fail++; $display("FAIL ecall sticky %0d: got %b want 0000101", i, {imem_req, dmem_req, reg_write, pc_write, state}); end
      @(negedge clk);
    end
    n_checks++;
    if (inst_q !== 32'h00000073) begin n_fail++; $display("FAIL ecall inst_q: got %h want 00000073", inst_q); end
    imem_ack = 0;
  endtask

  task automatic test_timeout();
    int n = 0;
    do_reset();
    imem_ack = 0;
    for (int c = 0; c < 40 && state != 3'd5; c++) begin
      #1;
      if (imem_req) n++;
      @(negedge clk);
    end
    #1;
    n_checks++;
    if (n !== TO) begin n_fail++; $display("FAIL timeout req cycles: got %0d want %0d", n, TO); end
    n_checks++;
    if ({state, halt_cause} !== {3'd5, 2'd3}) begin n_fail++; $display("FAIL timeout halt: got %0d/%0d want 5/3", state, halt_cause); end
    imem_ack = 1; imem_rdata = 32'h00500093;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({state, inst_q} !== {3'd5, NOP}) begin n_fail++; $display("FAIL ack while halted: got %0d/%h want 5/%h", state, inst_q, NOP); end
    imem_ack = 0;
  endtask

  task automatic test_illegal();
    do_reset();
    imem_rdata = 32'h0000007F; imem_ack = 1;
    repeat (2) @(negedge clk);
    imem_ack = 0;
    #1;
    n_checks++;
    if ({state, halted, halt_cause} !== {3'd5, 1'b1, 2'd2})
      begin n_fail++; $display("FAIL illegal halt: got %0d/%b/%0d want 5/1/2", state, halted, halt_cause); end
    n_checks++;
    if ({inst_q, instret} !== {32'h0000007F, 32'd0})
      begin n_fail++; $display("FAIL illegal inst_q/instret: got %h/%0d want 0000007f/0", inst_q, instret); end
  endtask

  task automatic test_reset_mid_mem();
    do_reset();
    run_inst("pre_addi", 32'h00500093, 0, 0, 1, 2'd0, 4, 30'o0124, 0, 0);
    imem_rdata = 32'h0000A103; imem_ack = 1;
    for (int c = 0; c < 6 && state != 3'd3; c++) @(negedge clk);
    imem_ack = 0;
    #1;
    n_checks++;
    if ({state, dmem_req} !== {3'd3, 1'b1}) begin n_fail++; $display("FAIL mid-mem entry: got %0d/%b want 3/1", state, dmem_req); end
    #1 rst = 0;
    #1;
    n_checks++;
    if ({state, dmem_req, imem_req} !== {3'd0, 2'b00}) begin n_fail++; $display("FAIL mid-mem reset: got %0d/%b/%b want 0/0/0", state, dmem_req, imem_req); end
    n_checks++;
    if ({inst_q, instret} !== {NOP, 32'd0}) begin n_fail++; $display("FAIL mid-mem reset regs: got %h/%0d want %h/0", inst_q, instret, NOP); end
    @(negedge clk);
    rst = 1;
    exp_ir = 0;
    sb.delete();
    #1;
    n_checks++;
    if (imem_req !== 1'b1) begin n_fail++; $display("FAIL restart imem_req: got %b want 1", imem_req); end
    run_inst("post_addi", 32'h00500093, 0, 0, 1, 2'd0, 4, 30'o0124, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu();
    test_mem();
    test_branch();
    test_back_to_back();
    test_ecall();
    test_timeout();
    test_illegal();
    test_reset_mid_mem();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
